// File: rtl/hsv_pkg.sv
// Shared HSV/RGB definitions: sector codes, output packing orders and
// pack/unpack helpers used by the quantiser and the HSV-to-RGB converter.
package hsv_pkg;

  // Widest component supported by the helpers; callers pass their own width.
  localparam int MAXW = 12;

  typedef enum logic [2:0] {
    SECT0 = 3'd0,
    SECT1 = 3'd1,
    SECT2 = 3'd2,
    SECT3 = 3'd3,
    SECT4 = 3'd4,
    SECT5 = 3'd5
  } sector_t;

  localparam logic ORDER_RGB = 1'b0;
  localparam logic ORDER_RBG = 1'b1;

  // Pack three w-bit components, first argument in the MSBs.
  function automatic logic [3*MAXW-1:0] pack3(input logic [MAXW-1:0] hi,
                                              input logic [MAXW-1:0] mid,
                                              input logic [MAXW-1:0] lo,
                                              input int unsigned w);
    return ((3*MAXW)'(hi) << (2*w)) | ((3*MAXW)'(mid) << w) | (3*MAXW)'(lo);
  endfunction

  // Extract component idx (0 = LSBs) of a packed triple of w-bit fields.
  function automatic logic [MAXW-1:0] unpackField(input logic [3*MAXW-1:0] word,
                                                  input int unsigned w,
                                                  input int unsigned idx);
    logic [3*MAXW-1:0] mask;
    mask = ((3*MAXW)'(1) << w) - (3*MAXW)'(1);
    return MAXW'((word >> (idx*w)) & mask);
  endfunction

  // Pack an RGB pixel in either the standard or the legacy {R,B,G} order.
  function automatic logic [3*MAXW-1:0] packRgb(input logic [MAXW-1:0] r,
                                                input logic [MAXW-1:0] g,
                                                input logic [MAXW-1:0] b,
                                                input int unsigned w,
                                                input logic order);
    return (order == ORDER_RBG) ? pack3(r, b, g, w) : pack3(r, g, b, w);
  endfunction

endpackage

// File: rtl/hsv_sector.sv
// Hue to sector/fraction split without a divider: X = H*6 via shift-add,
// the top three bits of X are the sector, the low W bits the fraction.
module hsv_sector #(
  parameter int W = 8
) (
  input  logic [W-1:0] hue,
  output logic [2:0]   sector,
  output logic [W-1:0] frac
);

  logic [W+2:0] hx6;

  // H*6 = H*4 + H*2
  assign hx6    = {1'b0, hue, 2'b00} + {2'b00, hue, 1'b0};
  assign sector = hx6[W+2:W];
  assign frac   = hx6[W-1:0];

endmodule

// File: rtl/hsv2rgb_pipe.sv
// Four-stage pipelined HSV-to-RGB converter with valid/ready backpressure
// and a sideband tag travelling alongside each pixel.
module hsv2rgb_pipe
  import hsv_pkg::*;
#(
  parameter int W     = 8,
  parameter int TAG_W = 1,
  parameter int ORDER = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3*W-1:0]   in_hsv,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [3*W-1:0]   out_rgb,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [W-1:0] MAX = '1;

  // Truncating fixed-point scale: (x*y) >> W, full 2W-bit product first.
  function automatic logic [W-1:0] scaleMul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] prod;
    prod = (2*W)'(x) * (2*W)'(y);
    return W'(prod >> W);
  endfunction

  logic stall, adv;
  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = adv;

  logic [W-1:0] hIn, sIn, vIn, fracIn;
  logic [2:0]   sectIn;
  assign hIn = W'(unpackField((3*MAXW)'(in_hsv), W, 2));
  assign sIn = W'(unpackField((3*MAXW)'(in_hsv), W, 1));
  assign vIn = W'(unpackField((3*MAXW)'(in_hsv), W, 0));

  hsv_sector #(.W(W)) uSector (
    .hue    (hIn),
    .sector (sectIn),
    .frac   (fracIn)
  );

  logic vld_p1, vld_p2, vld_p3;

  // Valid bits: cleared asynchronously, move forward whenever not stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      vld_p1    <= in_valid;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
      out_valid <= vld_p3;
    end
  end

  // ---- stage 1: capture S, V, tag, sector, fraction, grey flag ----
  logic [W-1:0]     s_p1, v_p1, frac_p1;
  logic [2:0]       sect_p1;
  logic             grey_p1;
  logic [TAG_W-1:0] tag_p1;

  // Stage 1 data register.
  always_ff @(posedge clk) begin
    if (adv) begin
      s_p1    <= sIn;
      v_p1    <= vIn;
      frac_p1 <= fracIn;
      sect_p1 <= sectIn;
      grey_p1 <= (sIn == '0);
      tag_p1  <= in_tag;
    end
  end

  // ---- stage 2: a = MAX-S, b = S*f, c = S*(MAX-f) ----
  logic [W-1:0]     a_p2, b_p2, c_p2, v_p2;
  logic [2:0]       sect_p2;
  logic             grey_p2;
  logic [TAG_W-1:0] tag_p2;

  // Stage 2 data register.
  always_ff @(posedge clk) begin
    if (adv) begin
      a_p2    <= MAX - s_p1;
      b_p2    <= scaleMul(s_p1, frac_p1);
      c_p2    <= scaleMul(s_p1, MAX - frac_p1);
      v_p2    <= v_p1;
      sect_p2 <= sect_p1;
      grey_p2 <= grey_p1;
      tag_p2  <= tag_p1;
    end
  end

  // ---- stage 3: P, Q, T ----
  logic [W-1:0]     p_p3, q_p3, t_p3, v_p3;
  logic [2:0]       sect_p3;
  logic             grey_p3;
  logic [TAG_W-1:0] tag_p3;

  // Stage 3 data register.
  always_ff @(posedge clk) begin
    if (adv) begin
      p_p3    <= scaleMul(v_p2, a_p2);
      q_p3    <= scaleMul(v_p2, MAX - b_p2);
      t_p3    <= scaleMul(v_p2, MAX - c_p2);
      v_p3    <= v_p2;
      sect_p3 <= sect_p2;
      grey_p3 <= grey_p2;
      tag_p3  <= tag_p2;
    end
  end

  // ---- stage 4: sector select and output packing ----
  logic [W-1:0]   rSel, gSel, bSel;
  logic [3*W-1:0] rgbSel;

  // Route V/P/Q/T to R/G/B by sector; unreachable codes give black.
  always_comb begin
    rSel = '0;
    gSel = '0;
    bSel = '0;
    if (grey_p3) begin
      rSel = v_p3; gSel = v_p3; bSel = v_p3;
    end else begin
      case (sect_p3)
        SECT0:   begin rSel = v_p3; gSel = t_p3; bSel = p_p3; end
        SECT1:   begin rSel = q_p3; gSel = v_p3; bSel = p_p3; end
        SECT2:   begin rSel = p_p3; gSel = v_p3; bSel = t_p3; end
        SECT3:   begin rSel = p_p3; gSel = q_p3; bSel = v_p3; end
        SECT4:   begin rSel = t_p3; gSel = p_p3; bSel = v_p3; end
        SECT5:   begin rSel = v_p3; gSel = p_p3; bSel = q_p3; end
        default: begin rSel = '0;   gSel = '0;   bSel = '0;   end
      endcase
    end
  end

  assign rgbSel = (3*W)'(packRgb(MAXW'(rSel), MAXW'(gSel), MAXW'(bSel), W, (ORDER != 0)));

  // Output register: cleared on reset, held while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_rgb <= '0;
      out_tag <= '0;
    end else if (adv) begin
      out_rgb <= rgbSel;
      out_tag <= tag_p3;
    end
  end

endmodule

// File: doc/hsv2rgb_pipe.md
Name: hsv2rgb_pipe

Overview:
Parametrised, fully pipelined HSV-to-RGB converter for the colour-reduction path. Component width is configurable and sector/fraction are computed without a divider core. A valid/ready handshake with backpressure is provided, along with a sideband tag carried alongside each pixel. Sits between the HSV quantiser and the frame-buffer/VGA pixel writer and replaces the fixed 8-bit, unhandshaked converter.

Parameters:
W, 8, bits per component (H, S, V, R, G, B); legal 4..12
TAG_W, 1, width of sideband tag passed through with each pixel (e.g. pixel-valid/hsync flags)
ORDER, 1, output packing: 0 = {R,G,B}; 1 = {R,B,G} (legacy packing used by existing downstream)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
in_hsv  input  3*W  {H,S,V}, H in MSBs
in_tag  input  TAG_W  sideband, travels with pixel
in_valid  input  1  input pixel present
in_ready  output  1  converter accepts input this cycle
out_rgb  output  3*W  packed per ORDER
out_tag  output  TAG_W  tag of the pixel on out_rgb
out_valid  output  1  out_rgb/out_tag valid
out_ready  input  1  downstream accepts output

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: all stage valid bits 0; out_valid=0, out_rgb=0, out_tag=0. in_ready follows the stall rule below, so it is 1 while in reset.
- Reset mid-operation: all in-flight pixels are discarded and nothing is emitted for them.
- Constants: MAX = 2^W-1.
- Handshake: a transfer occurs when valid && ready on a side.
- Stall rule: stall = out_valid && !out_ready. in_ready = !stall, so it is combinational from out_ready.
- On stall, every pipeline register holds, including outputs. out_rgb and out_tag stay stable while out_valid && !out_ready.
- Bubbles advance freely; a bubble never stalls the pipe.
- Throughput: 1 pixel/clk when out_ready is high.
- Latency: 4 cycles. A pixel accepted at edge N appears with out_valid=1 after edge N+4, with no stalls in between.
- Stage 1 (capture and sector):
  - X = H*6, width W+3.
  - sector = X >> W, always in 0..5.
  - f = X[W-1:0].
  - Register S, V, tag, sector, f and a grey flag (S==0).
- Stage 2 (partial products), each truncated by >>W to W bits:
  - a = MAX-S
  - b = (S*f) >> W
  - c = (S*(MAX-f)) >> W
- Stage 3 (P, Q, T), each truncated by >>W, result W bits, no rounding:
  - P = (V*a) >> W
  - Q = (V*(MAX-b)) >> W
  - T = (V*(MAX-c)) >> W
- Stage 4 (select), registered output:
  - grey: R=G=B=V.
  - sector 0: (V,T,P)
  - sector 1: (Q,V,P)
  - sector 2: (P,V,T)
  - sector 3: (P,Q,V)
  - sector 4: (T,P,V)
  - sector 5: (V,P,Q)
  - Sectors 6/7 are unreachable. If they occur anyway, output (0,0,0).
- Hue wrap: H=MAX lands in sector 5 with f near MAX. There is no wrap to sector 0.
- Arithmetic is unsigned. No intermediate overflows: products are 2W bits wide before the shift.

Decomposition:
- Shared package hsv_pkg holds:
  - the sector encodings SECT0..SECT5
  - the ORDER_RGB/ORDER_RBG constants
  - the pack/unpack helper functions used by the quantiser and this block
- One natural sub-module: hsv_sector (combinational H -> sector, f; H*6 via shift-add) so the quantiser can reuse it.
- Pipeline registers and stall logic stay in the top module.

Test Plan:
All scenarios use W=8, ORDER=0 unless stated.
1. Basic conversions, each -> R,G,B with out_valid exactly 4 cycles after acceptance:
   - H=0, S=255, V=255 -> 255,0,0
   - H=85, S=255, V=255 -> 1,255,0
   - H=128, S=255, V=200 -> 0,199,200
2. Grey and wrap:
   - H=200, S=0, V=77 -> 77,77,77
   - H=255, S=128, V=255 (sector 5, f=250) -> 255,126,129
3. Streaming with backpressure: 32 back-to-back pixels with incrementing tags; out_ready toggled pseudo-randomly -> every pixel emitted exactly once, in order, tags matching. While stalled, out_rgb is stable and in_ready=0.
4. Bubbles: in_valid pattern 1,0,0,1,1,0 with out_ready=1 -> out_valid shows the same pattern delayed by 4 cycles.
5. Reset mid-stream: assert reset with 3 pixels in flight -> out_valid drops to 0 asynchronously, out_rgb=0, and no stale pixel appears after release. The next accepted pixel is emitted 4 cycles later.
6. ORDER=1 build: H=128, S=255, V=200 -> out_rgb = {0,200,199}. Also run a W=6 build with H=63, S=63, V=63 checked against a reference model using the same formulas.
